// File: rtl/sram_like_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_like_arbiter: shares one sram-like port between fetch (m0) and data  |
// | (m1) requesters, returning responses in order. Revision: 1.0             |
// +--------------------------------------------------------------------------+
module sram_like_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter bit DATA_PRIO   = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e            state_q, state_d;
  logic                   lock_id_q, lock_id_d;
  logic                   last_grant_q, last_grant_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [OUTSTANDING-1:0] order_q, order_d;

  logic grant;
  logic grant_req;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_id;

  always_comb begin
    grant = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant = lock_id_q;
    end else if (m0_req && m1_req) begin
      grant = DATA_PRIO ? 1'b1 : ~last_grant_q;
    end else begin
      grant = m1_req;
    end
  end

  assign grant_req = grant ? m1_req : m0_req;
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);

  // No bypass when full: a same-cycle pop does not free a slot until next cycle.
  assign s_req   = grant_req & ~full & rstn;
  assign s_wr    = grant ? m1_wr    : m0_wr;
  assign s_size  = grant ? m1_size  : m0_size;
  assign s_wstrb = grant ? m1_wstrb : m0_wstrb;
  assign s_addr  = grant ? m1_addr  : m0_addr;
  assign s_wdata = grant ? m1_wdata : m0_wdata;

  assign push    = s_req & s_addr_ok;
  assign pop     = s_data_ok & ~empty & rstn;
  assign head_id = order_q[head_q];

  assign m0_addr_ok = push & ~grant;
  assign m1_addr_ok = push & grant;
  assign m0_data_ok = pop & ~head_id;
  assign m1_data_ok = pop & head_id;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  always_comb begin
    state_d      = state_q;
    lock_id_d    = lock_id_q;
    last_grant_d = last_grant_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    order_d      = order_q;

    // Hold the grant across a stalled address phase so fields stay stable.
    case (state_q)
      ST_OPEN: begin
        if (s_req && !s_addr_ok) begin
          state_d   = ST_LOCKED;
          lock_id_d = grant;
        end
      end
      ST_LOCKED: begin
        if (push) begin
          state_d = ST_OPEN;
        end
      end
      default: begin
        state_d = ST_OPEN;
      end
    endcase

    if (push) begin
      order_d[tail_q] = grant;
      tail_d          = tail_q + PTR_W'(1);
      last_grant_d    = grant;
    end

    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_OPEN;
      lock_id_q    <= 1'b0;
      last_grant_q <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      order_q      <= '0;
    end else begin
      state_q      <= state_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      order_q      <= order_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_like_arbiter: random traffic against a queue-based reference for  |
// | both priority modes. Revision: 1.0                                        |
// +--------------------------------------------------------------------------+
module tb_sram_like_arbiter;

  localparam int OUT = 4;

  logic clk = 1'b0;
  logic rstn;
  int   phase;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  for (genvar p = 0; p < 2; p++) begin : g_inst
    localparam bit DPRIO = (p == 1);

    logic [1:0]       mreq;
    logic [1:0]       mwr;
    logic [1:0][1:0]  msize;
    logic [1:0][3:0]  mwstrb;
    logic [1:0][31:0] maddr;
    logic [1:0][31:0] mwdata;
    logic             m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0]      m0_rdata, m1_rdata;
    logic             s_req, s_wr;
    logic [1:0]       s_size;
    logic [3:0]       s_wstrb;
    logic [31:0]      s_addr, s_wdata;
    logic             s_addr_ok, s_data_ok;
    logic [31:0]      s_rdata;

    // Reference state: lock holder, last winner and the order of accepted owners.
    bit [1:0] acc;
    bit       lk, lk_id, last, g, exp_sreq, exp_pop;
    int       owner;
    int       ord_q[$];

    sram_like_arbiter #(
      .OUTSTANDING(OUT),
      .DATA_PRIO  (DPRIO)
    ) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .m0_req    (mreq[0]),
      .m0_wr     (mwr[0]),
      .m0_size   (msize[0]),
      .m0_wstrb  (mwstrb[0]),
      .m0_addr   (maddr[0]),
      .m0_wdata  (mwdata[0]),
      .m0_addr_ok(m0_addr_ok),
      .m0_data_ok(m0_data_ok),
      .m0_rdata  (m0_rdata),
      .m1_req    (mreq[1]),
      .m1_wr     (mwr[1]),
      .m1_size   (msize[1]),
      .m1_wstrb  (mwstrb[1]),
      .m1_addr   (maddr[1]),
      .m1_wdata  (mwdata[1]),
      .m1_addr_ok(m1_addr_ok),
      .m1_data_ok(m1_data_ok),
      .m1_rdata  (m1_rdata),
      .s_req     (s_req),
      .s_wr      (s_wr),
      .s_size    (s_size),
      .s_wstrb   (s_wstrb),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_addr_ok (s_addr_ok),
      .s_data_ok (s_data_ok),
      .s_rdata   (s_rdata)
    );

    initial begin
      mreq = '0; mwr = '0; msize = '0; mwstrb = '0; maddr = '0; mwdata = '0;
      s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
      forever begin
        @(posedge clk); #1;
        for (int j = 0; j < 2; j++) begin
          if (mreq[j] && acc[j]) mreq[j] = 1'b0;
          if (!mreq[j] && ($urandom_range(0, 2) != 0)) begin
            mreq[j]   = 1'b1;
            mwr[j]    = 1'($urandom);
            msize[j]  = 2'($urandom);
            mwstrb[j] = 4'($urandom);
            maddr[j]  = $urandom;
            mwdata[j] = $urandom;
          end
        end
        s_addr_ok = ($urandom_range(0, 9) < 7);
        case (phase)
          1:       s_data_ok = ($urandom_range(0, 7) == 0);
          2:       s_data_ok = ($urandom_range(0, 9) != 0);
          default: s_data_ok = 1'($urandom);
        endcase
        s_rdata = $urandom;
      end
    end

    always @(negedge clk) begin
      if (!rstn) begin
        check($sformatf("i%0d_rst_s_req", p), s_req, 0);
        check($sformatf("i%0d_rst_addr_ok", p), {m1_addr_ok, m0_addr_ok}, 0);
        check($sformatf("i%0d_rst_data_ok", p), {m1_data_ok, m0_data_ok}, 0);
        lk = 1'b0; last = 1'b0; acc = '0;
        ord_q.delete();
      end else begin
        if (lk)                      g = lk_id;
        else if (mreq[0] && mreq[1]) g = DPRIO ? 1'b1 : ~last;
        else                         g = mreq[1];
        exp_sreq = mreq[g] && (ord_q.size() < OUT);
        check($sformatf("i%0d_s_req", p), s_req, exp_sreq);
        if (exp_sreq)
          check($sformatf("i%0d_s_fields", p), {s_wr, s_size, s_wstrb, s_addr, s_wdata},
                {mwr[g], msize[g], mwstrb[g], maddr[g], mwdata[g]});
        acc[0] = exp_sreq && s_addr_ok && !g;
        acc[1] = exp_sreq && s_addr_ok && g;
        check($sformatf("i%0d_m0_addr_ok", p), m0_addr_ok, acc[0]);
        check($sformatf("i%0d_m1_addr_ok", p), m1_addr_ok, acc[1]);

        exp_pop = s_data_ok && (ord_q.size() > 0);
        owner   = exp_pop ? ord_q[0] : -1;
        check($sformatf("i%0d_m0_data_ok", p), m0_data_ok, exp_pop && owner == 0);
        check($sformatf("i%0d_m1_data_ok", p), m1_data_ok, exp_pop && owner == 1);
        if (exp_pop) begin
          check($sformatf("i%0d_rdata", p), {m1_rdata, m0_rdata}, {s_rdata, s_rdata});
          void'(ord_q.pop_front());
        end

        if (exp_sreq && s_addr_ok) begin
          ord_q.push_back(int'(g));
          last = g;
          lk   = 1'b0;
        end else if (exp_sreq) begin
          lk    = 1'b1;
          lk_id = g;
        end
      end
    end
  end

  initial begin
    rstn  = 1'b0;
    phase = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      phase = k % 3;
      repeat (200) @(posedge clk);
      if (k == 4) begin
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
      end
    end
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the Fetch instruction requester (master 0) and the Excute/Memory data requester (master 1).
- Arbitrates request phases and holds a grant until the address handshake completes.
- Records the owner of each accepted request in an order FIFO, so every data_ok/rdata is returned to the correct master in order.
- Sits between the core's inst_sram/data_sram interfaces and the single memory/bridge port.

Parameters:
- OUTSTANDING, 4, order-FIFO depth (max accepted-but-unanswered requests); power of 2, ≥2
- DATA_PRIO, 1, 1 = master 1 always wins contention; 0 = round-robin on last-granted master

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- m0_req  in  1  inst request
- m0_wr  in  1  inst write flag
- m0_size  in  2  inst access size
- m0_wstrb  in  4  inst byte strobes
- m0_addr  in  32  inst address
- m0_wdata  in  32  inst write data
- m0_addr_ok  out  1  inst request accepted
- m0_data_ok  out  1  inst response valid
- m0_rdata  out  32  inst read data
- m1_req, m1_wr, m1_size, m1_wstrb, m1_addr, m1_wdata  in  1/1/2/4/32/32  data request fields, same meaning as m0
- m1_addr_ok  out  1  data request accepted
- m1_data_ok  out  1  data response valid
- m1_rdata  out  32  data read data
- s_req  out  1  request to memory
- s_wr  out  1  memory write flag
- s_size  out  2  memory access size
- s_wstrb  out  4  memory byte strobes
- s_addr  out  32  memory address
- s_wdata  out  32  memory write data
- s_addr_ok  in  1  memory accepted request
- s_data_ok  in  1  memory response valid
- s_rdata  in  32  memory read data

Behaviour:
- Clock and reset: single clock clk. Reset rstn is synchronous, active-low.
- Reset values: FIFO empty, count=0, lock=0, last_grant=0. While rstn=0, force s_req, m0/m1_addr_ok and m0/m1_data_ok to 0.
- Protocol: a master holds req and all request fields stable from assertion until its addr_ok. One request is accepted per cycle, on s_req & s_addr_ok.
- Arbitration, when lock=0:
  - Only one master requesting: grant it.
  - Both requesting, DATA_PRIO=1: grant m1.
  - Both requesting, DATA_PRIO=0: grant the master ≠ last_grant.
- Locking: if s_req=1 and s_addr_ok=0, set lock=1 and latch lock_id=grant. While lock=1, grant=lock_id regardless of the other master. Clear lock on s_addr_ok.
- Request mux: s_* fields = fields of the granted master, combinational. s_req = granted master's req & ~full & rstn.
- Full back-pressure: when count==OUTSTANDING, s_req=0 even if a pop occurs in the same cycle. There is no bypass, so push is allowed only from the next cycle.
- Address handshake: m{grant}_addr_ok = s_addr_ok & s_req, same cycle. The other master's addr_ok is 0. On acceptance: push grant id, last_grant ← grant.
- Response return: on s_data_ok with count>0, pop the head id and drive m{head}_data_ok=1 in the same cycle. The other master's data_ok is 0.
- Read data: m0_rdata = m1_rdata = s_rdata, unconditionally.
- Empty FIFO: s_data_ok with count==0 is dropped. No data_ok is asserted and count stays 0.
- Simultaneous push and pop (not full): count unchanged. Head advances, tail advances.
- Pointers: wrap modulo OUTSTANDING, width log2(OUTSTANDING). count width log2(OUTSTANDING)+1.
- Same-cycle accept and response: a response can never belong to the request accepted in the same cycle. Pop uses the head before the push.
- Latency: zero-cycle combinational path for request and handshakes. State updates on clk rising edge.
- Reset mid-operation: outstanding entries are discarded. Memory responses arriving after reset hit the empty-FIFO rule.

Test Plan:
- Both masters request with different addresses (m0 0x1c000000, m1 0x00001000), DATA_PRIO=1, s_addr_ok=1 → cycle 1: s_addr=0x1000, m1_addr_ok=1. Cycle 2: s_addr=0x1c000000, m0_addr_ok=1. FIFO holds [1,0].
- Lock: m0 requests, s_addr_ok held 0 for 3 cycles, m1 requests in cycle 2 → s_addr stays m0's for all 4 cycles. m0_addr_ok=1 only in cycle 4. m1 granted in cycle 5.
- Ordering: accept m0, m1, m0. Return s_data_ok with rdata 0xA,0xB,0xC → m0_data_ok, then m1_data_ok, then m0_data_ok, with rdata 0xA,0xB,0xC respectively.
- Full: OUTSTANDING=4, 4 requests accepted with no responses, a 5th m1 request → s_req=0. A pop in that same cycle still leaves s_req=0. The 5th request is accepted the following cycle.
- Round-robin: DATA_PRIO=0, both masters request continuously, s_addr_ok=1 → grants alternate 1,0,1,0 after reset (last_grant=0 at reset).
- Reset with 2 outstanding, then s_data_ok=1 → no data_ok to either master, count=0.
